// File: rtl/fifo_wr_arbiter.sv
// Round-robin frame arbiter sharing one FIFO write port between PORTS requesters.
// Optional watchdog (forced release of a stalled grant) enabled by FIFO_ARB_WATCHDOG_EN.
module fifo_wr_arbiter #(
    parameter int PORTS   = 4,
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS*WIDTH-1:0]   s_data,
    input  logic [PORTS-1:0]         s_valid,
    input  logic [PORTS-1:0]         s_last,
    output logic [PORTS-1:0]         s_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [$clog2(PORTS)-1:0] grant_id,
`ifdef FIFO_ARB_WATCHDOG_EN
    output logic                     err_timeout,
`endif
    output logic                     busy
);

    // state | meaning
    // IDLE  | no grant held; pick next valid port after rr_last
    // XFER  | grant_id owns the FIFO write port until its last beat
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam int IDW = $clog2(PORTS);

    if (PORTS < 2 || PORTS > 16 || TIMEOUT < 2) begin : g_bad_param
        $error("fifo_wr_arbiter: PORTS must be 2..16 and TIMEOUT at least 2");
    end

    logic [0:0]       state;
    logic [IDW-1:0]   rr_last;
    logic [IDW-1:0]   arb_pick;
    logic [IDW-1:0]   cand;
    logic             arb_hit;
    logic             cur_valid;
    logic             cur_last;
    logic             beat_acc;
    logic [WIDTH-1:0] port_data [PORTS];

    for (genvar g = 0; g < PORTS; g++) begin : g_slice
        assign port_data[g] = s_data[g*WIDTH +: WIDTH];
    end

    // Scan from farthest to nearest offset so the port right after rr_last wins.
    always_comb begin
        arb_hit  = 1'b0;
        arb_pick = '0;
        cand     = '0;
        for (int i = PORTS; i >= 1; i--) begin
            cand = IDW'((int'(rr_last) + i) % PORTS);
            if (s_valid[cand]) begin
                arb_hit  = 1'b1;
                arb_pick = cand;
            end
        end
    end

    assign busy       = (state == ST_XFER);
    assign cur_valid  = s_valid[grant_id];
    assign cur_last   = s_last[grant_id];
    assign beat_acc   = busy && cur_valid && !fifo_full;
    assign fifo_wr_en = beat_acc;
    assign fifo_data  = busy ? port_data[grant_id] : '0;

    always_comb begin
        s_ready = '0;
        if (busy && !fifo_full) begin
            s_ready[grant_id] = 1'b1;
        end
    end

`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_cnt;
    logic          wd_expire;

    // Down-counter reloaded on grant and on every accepted beat; terminal count ends the grant.
    assign wd_expire = busy && !cur_valid && (stall_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= CW'(TIMEOUT);
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_expire;
            if (!busy) begin
                stall_cnt <= CW'(TIMEOUT);
            end else if (beat_acc) begin
                stall_cnt <= CW'(TIMEOUT);
            end else if (!cur_valid) begin
                stall_cnt <= stall_cnt - CW'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_last  <= IDW'(PORTS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_hit) begin
                        grant_id <= arb_pick;
                        state    <= ST_XFER;
                    end
                end
                default: begin
                    if (beat_acc && cur_last) begin
                        rr_last <= grant_id;
                        state   <= ST_IDLE;
                    end
`ifdef FIFO_ARB_WATCHDOG_EN
                    else if (wd_expire) begin
                        rr_last <= grant_id;
                        state   <= ST_IDLE;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: arbitration vector table plus frame-level sequences.
// Build with FIFO_ARB_WATCHDOG_EN defined to also exercise the watchdog release.
module tb_fifo_wr_arbiter;

    localparam int PORTS   = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;
`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 10;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        logic [PORTS-1:0] vmask;
        int               exp_grant;
    } arb_vec_t;

    logic                   clk;
    logic                   rst_n;
    logic [PORTS*WIDTH-1:0] s_data;
    logic [PORTS-1:0]       s_valid;
    logic [PORTS-1:0]       s_last;
    logic [PORTS-1:0]       s_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_data;
    logic [1:0]             grant_id;
    logic                   busy;
`ifdef FIFO_ARB_WATCHDOG_EN
    logic                   err_timeout;
`endif

    fifo_wr_arbiter #(.PORTS(PORTS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
`ifdef FIFO_ARB_WATCHDOG_EN
        .err_timeout(err_timeout),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t            port_q [PORTS][$];
    logic [WIDTH-1:0] exp_data_q [$];
    int               exp_grant_q [$];
    logic [PORTS-1:0] en;
    int               n_checks;
    int               n_errors;
    int               seq;
    logic             prev_busy;
    logic             smp_busy;
    logic             smp_wr;
    logic             smp_err;
    logic [1:0]       smp_grant;
    logic [PORTS-1:0] smp_ready;
    arb_vec_t         vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk_word(input int p);
        logic [WIDTH-1:0] w;
        w   = {p[3:0], seq[11:0]};
        seq = seq + 1;
        return w;
    endfunction

    task automatic refresh();
        for (int p = 0; p < PORTS; p++) begin
            if (en[p] && port_q[p].size() > 0) begin
                s_valid[p]                = 1'b1;
                s_last[p]                 = port_q[p][0].last;
                s_data[p*WIDTH +: WIDTH]  = port_q[p][0].data;
            end else begin
                s_valid[p]                = 1'b0;
                s_last[p]                 = 1'b0;
                s_data[p*WIDTH +: WIDTH]  = '0;
            end
        end
    endtask

    task automatic load_frame(input int p, input int nbeats, input bit push_exp);
        logic [WIDTH-1:0] w;
        for (int b = 0; b < nbeats; b++) begin
            w = mk_word(p);
            port_q[p].push_back('{data: w, last: (b == nbeats - 1)});
            if (push_exp) exp_data_q.push_back(w);
        end
    endtask

    task automatic clear_ports();
        for (int p = 0; p < PORTS; p++) port_q[p].delete();
    endtask

    // Samples mid-cycle, scores writes and new grants, then advances requester queues.
    task automatic cycle();
        logic [PORTS-1:0] acc;
        @(negedge clk);
        smp_busy  = busy;
        smp_grant = grant_id;
        smp_wr    = fifo_wr_en;
        smp_ready = s_ready;
`ifdef FIFO_ARB_WATCHDOG_EN
        smp_err   = err_timeout;
`else
        smp_err   = 1'b0;
`endif
        acc = s_valid & s_ready;
        if (fifo_full) chk("wr_while_full", {31'd0, fifo_wr_en}, 32'd0);
        if (fifo_wr_en) begin
            if (exp_data_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got data %0h, expected no write", fifo_data);
            end else begin
                chk("fifo_data", {16'd0, fifo_data}, {16'd0, exp_data_q.pop_front()});
            end
        end
        if (busy && !prev_busy) begin
            if (exp_grant_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_grant: got port %0d, expected no grant", grant_id);
            end else begin
                chk("grant_order", {30'd0, grant_id}, exp_grant_q.pop_front());
            end
        end
        prev_busy = busy;
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                if (acc[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
            end
        end
        refresh();
    endtask

    initial begin
        logic [WIDTH-1:0] w [5];
        int               wr_cnt;

        vec[0] = '{vmask: 4'b1111, exp_grant: 0};
        vec[1] = '{vmask: 4'b1001, exp_grant: 3};
        vec[2] = '{vmask: 4'b0101, exp_grant: 0};
        vec[3] = '{vmask: 4'b0101, exp_grant: 2};
        vec[4] = '{vmask: 4'b0010, exp_grant: 1};
        vec[5] = '{vmask: 4'b0010, exp_grant: 1};
        vec[6] = '{vmask: 4'b1100, exp_grant: 2};
        vec[7] = '{vmask: 4'b1111, exp_grant: 3};

        n_checks  = 0;
        n_errors  = 0;
        seq       = 0;
        prev_busy = 1'b0;
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        en        = '1;
        s_data    = '0;
        s_valid   = '0;
        s_last    = '0;
        refresh();
        #12;
        chk("rst_busy",     {31'd0, busy},       32'd0);
        chk("rst_grant_id", {30'd0, grant_id},   32'd0);
        chk("rst_wr_en",    {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_s_ready",  {28'd0, s_ready},    32'd0);
        chk("rst_data",     {16'd0, fifo_data},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arbitration table: single-beat frames on every port in vmask, one grant per record.
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (vec[r].vmask[p]) load_frame(p, 1, p == vec[r].exp_grant);
            end
            exp_grant_q.push_back(vec[r].exp_grant);
            refresh();
            cycle();
            chk($sformatf("vec%0d_idle_busy", r), {31'd0, smp_busy}, 32'd0);
            cycle();
            chk($sformatf("vec%0d_grant", r), {30'd0, smp_grant}, vec[r].exp_grant);
            chk($sformatf("vec%0d_ready", r), {28'd0, smp_ready}, 32'd1 << vec[r].exp_grant);
            chk($sformatf("vec%0d_wr", r), {31'd0, smp_wr}, 32'd1);
            clear_ports();
            refresh();
        end

        // All ports valid with 2-beat frames: order 0,1,2,3,0 and 2 writes per 3 cycles.
        load_frame(0, 2, 1);
        load_frame(1, 2, 1);
        load_frame(2, 2, 1);
        load_frame(3, 2, 1);
        load_frame(0, 2, 1);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        refresh();
        wr_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            cycle();
            wr_cnt += int'(smp_wr);
        end
        chk("rr4_writes", wr_cnt, 10);
        chk("rr4_data_left", exp_data_q.size(), 0);
        chk("rr4_grant_left", exp_grant_q.size(), 0);

        // Only port 2, back-to-back single-beat frames: one write every 2 cycles.
        for (int f = 0; f < 4; f++) begin
            load_frame(2, 1, 1);
            exp_grant_q.push_back(2);
        end
        refresh();
        wr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            wr_cnt += int'(smp_wr);
            chk("p2_wr_pattern", {31'd0, smp_wr}, c % 2);
            if (smp_busy) chk("p2_grant", {30'd0, smp_grant}, 32'd2);
        end
        chk("p2_writes", wr_cnt, 4);

        // Port 1 4-beat frame, FIFO full for 5 cycles after beat 2.
        load_frame(1, 4, 1);
        exp_grant_q.push_back(1);
        refresh();
        for (int c = 0; c < 3; c++) cycle();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("full_ready", {28'd0, smp_ready}, 32'd0);
            chk("full_wr", {31'd0, smp_wr}, 32'd0);
            chk("full_busy", {31'd0, smp_busy}, 32'd1);
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("full_resume_wr", {31'd0, smp_wr}, 32'd1);
        end
        chk("full_data_left", exp_data_q.size(), 0);
        chk("full_port_left", port_q[1].size(), 0);

        // Port 0 drops valid mid-frame while port 3 waits; grant must not move.
        load_frame(0, 4, 1);
        exp_grant_q.push_back(0);
        refresh();
        cycle();
        cycle();
        en[0] = 1'b0;
        load_frame(3, 1, 1);
        exp_grant_q.push_back(3);
        refresh();
        for (int c = 0; c < HOLD; c++) begin
            cycle();
            chk("hold_grant", {30'd0, smp_grant}, 32'd0);
            chk("hold_ready", {28'd0, smp_ready}, 32'b0001);
            chk("hold_wr", {31'd0, smp_wr}, 32'd0);
        end
        en[0] = 1'b1;
        refresh();
        for (int c = 0; c < 3; c++) cycle();
        cycle();
        chk("hold_gap_busy", {31'd0, smp_busy}, 32'd0);
        cycle();
        chk("hold_pass_grant", {30'd0, smp_grant}, 32'd3);
        chk("hold_data_left", exp_data_q.size(), 0);

        // Asynchronous reset in the middle of a port 1 frame.
        load_frame(1, 3, 1);
        load_frame(2, 1, 1);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        refresh();
        cycle();
        cycle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_busy",     {31'd0, busy},       32'd0);
        chk("async_wr_en",    {31'd0, fifo_wr_en}, 32'd0);
        chk("async_s_ready",  {28'd0, s_ready},    32'd0);
        chk("async_data",     {16'd0, fifo_data},  32'd0);
        chk("async_grant_id", {30'd0, grant_id},   32'd0);
        clear_ports();
        exp_data_q.delete();
        exp_grant_q.delete();
        refresh();
        cycle();
        cycle();
        #1;
        rst_n = 1'b1;
        load_frame(1, 3, 1);
        load_frame(2, 1, 1);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        refresh();
        prev_busy = 1'b0;
        for (int c = 0; c < 6; c++) cycle();
        chk("rst_data_left", exp_data_q.size(), 0);
        chk("rst_grant_left", exp_grant_q.size(), 0);

`ifdef FIFO_ARB_WATCHDOG_EN
        // Port 0 stalls after beat 1; watchdog releases after TIMEOUT cycles and port 3 follows.
        for (int b = 0; b < 4; b++) begin
            w[b] = mk_word(0);
            port_q[0].push_back('{data: w[b], last: (b == 3)});
        end
        w[4] = mk_word(3);
        exp_data_q.push_back(w[0]);
        exp_data_q.push_back(w[4]);
        exp_data_q.push_back(w[1]);
        exp_data_q.push_back(w[2]);
        exp_data_q.push_back(w[3]);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        refresh();
        cycle();
        cycle();
        en[0] = 1'b0;
        port_q[3].push_back('{data: w[4], last: 1'b1});
        refresh();
        for (int c = 0; c < TIMEOUT; c++) begin
            cycle();
            chk("wd_stall_busy", {31'd0, smp_busy}, 32'd1);
            chk("wd_stall_err", {31'd0, smp_err}, 32'd0);
        end
        cycle();
        chk("wd_release_busy", {31'd0, smp_busy}, 32'd0);
        chk("wd_pulse", {31'd0, smp_err}, 32'd1);
        cycle();
        chk("wd_next_grant", {30'd0, smp_grant}, 32'd3);
        chk("wd_pulse_end", {31'd0, smp_err}, 32'd0);
        en[0] = 1'b1;
        refresh();
        for (int c = 0; c < 4; c++) cycle();
        chk("wd_data_left", exp_data_q.size(), 0);
`else
        w[0] = '0;
`endif

        chk("final_grant_left", exp_grant_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
